// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: data-phase state encoding,
// requester port indices and default bus widths.
package mem_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  localparam int unsigned PORT_C = 0;
  localparam int unsigned PORT_D = 1;
  localparam int unsigned NUM_PORTS = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD_C = 2'd1;
  localparam logic [1:0] RD_D = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRdC  = RD_C,
    StRdD  = RD_D
  } state_e;

endpackage

// File: rtl/arb_age_cnt.sv
// Saturating wait counter for one low-priority requester. promote_o is raised once the
// requester has been denied MaxWait consecutive cycles.
module arb_age_cnt #(
  parameter int unsigned MaxWait = 4,
  parameter int unsigned CntW    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic gnt_i,
  output logic promote_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max = (cnt_q == CntW'(MaxWait));

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = '0;
    end else if (!at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign promote_o = at_max;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the core's unified memory: fixed priority to the core,
// with an aging counter that periodically lets the DMA port through.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wd,
  output logic          c_gnt,
  output logic [DW-1:0] c_rd,
  output logic          c_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wd,
  output logic          d_gnt,
  output logic [DW-1:0] d_rd,
  output logic          d_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic                 promote;
  logic [NUM_PORTS-1:0] gnt;
  state_e               state_q, state_d;

  arb_age_cnt #(
    .MaxWait(MAXWAIT),
    .CntW   (4)
  ) u_age_cnt (
    .clk      (clk),
    .reset    (reset),
    .req_i    (d_req),
    .gnt_i    (gnt[PORT_D]),
    .promote_o(promote)
  );

  // Grants are masked while reset is held so every output reads 0 during reset.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      if (promote && d_req) begin
        gnt[PORT_D] = 1'b1;
      end else if (c_req) begin
        gnt[PORT_C] = 1'b1;
      end else if (d_req) begin
        gnt[PORT_D] = 1'b1;
      end
    end
  end

  assign c_gnt = gnt[PORT_C];
  assign d_gnt = gnt[PORT_D];

  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_wd  = '0;
    unique case (gnt)
      2'b01: begin
        mem_en  = 1'b1;
        mem_we  = c_we;
        mem_adr = c_adr;
        mem_wd  = c_wd;
      end
      2'b10: begin
        mem_en  = 1'b1;
        mem_we  = d_we;
        mem_adr = d_adr;
        mem_wd  = d_wd;
      end
      default: ;
    endcase
  end

  // Data-phase tracking: the next state depends only on this cycle's grant, so a new
  // address phase can overlap the previous read's data phase.
  always_comb begin
    state_d = StIdle;
    if (gnt[PORT_C] && !c_we) begin
      state_d = StRdC;
    end else if (gnt[PORT_D] && !d_we) begin
      state_d = StRdD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign c_rvalid = (state_q == StRdC);
  assign d_rvalid = (state_q == StRdD);
  assign c_rd     = c_rvalid ? mem_rd : '0;
  assign d_rd     = d_rvalid ? mem_rd : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous memory behind it.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [31:0] c_adr, c_wd, c_rd;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_adr, d_wd, d_rd;
  logic        mem_en, mem_we;
  logic [31:0] mem_adr, mem_wd, mem_rd;

  logic [31:0] mem [64];
  int          n_checks;
  int          n_errors;

  mem_arbiter #(
    .AW     (32),
    .DW     (32),
    .MAXWAIT(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_adr   (c_adr),
    .c_wd    (c_wd),
    .c_gnt   (c_gnt),
    .c_rd    (c_rd),
    .c_rvalid(c_rvalid),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_adr   (d_adr),
    .d_wd    (d_wd),
    .d_gnt   (d_gnt),
    .d_rd    (d_rd),
    .d_rvalid(d_rvalid),
    .mem_en  (mem_en),
    .mem_we  (mem_we),
    .mem_adr (mem_adr),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_adr[7:2]] <= mem_wd;
    if (mem_en && !mem_we) mem_rd <= mem[mem_adr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, checks follow #1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".c_gnt"}, {31'b0, c_gnt}, 32'd0);
    chk({tag, ".d_gnt"}, {31'b0, d_gnt}, 32'd0);
    chk({tag, ".c_rvalid"}, {31'b0, c_rvalid}, 32'd0);
    chk({tag, ".d_rvalid"}, {31'b0, d_rvalid}, 32'd0);
    chk({tag, ".mem_en"}, {31'b0, mem_en}, 32'd0);
    chk({tag, ".mem_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, ".mem_adr"}, mem_adr, 32'd0);
    chk({tag, ".mem_wd"}, mem_wd, 32'd0);
    chk({tag, ".c_rd"}, c_rd, 32'd0);
    chk({tag, ".d_rd"}, d_rd, 32'd0);
  endtask

  initial begin
    logic exp_d;
    logic prev_d;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[4] = 32'hE3A0_1005;
    mem_rd = '0;
    reset = 1'b1;
    c_req = 0; c_we = 0; c_adr = '0; c_wd = '0;
    d_req = 0; d_we = 0; d_adr = '0; d_wd = '0;

    // Reset state
    cyc(); cyc();
    #1 chk_idle_outputs("reset");
    reset = 1'b0;
    cyc();

    // Core-only read of 0x10
    c_req = 1; c_we = 0; c_adr = 32'h10;
    #1;
    chk("rd_c.c_gnt", {31'b0, c_gnt}, 32'd1);
    chk("rd_c.mem_en", {31'b0, mem_en}, 32'd1);
    chk("rd_c.mem_we", {31'b0, mem_we}, 32'd0);
    chk("rd_c.mem_adr", mem_adr, 32'h10);
    cyc();
    c_req = 0;
    #1;
    chk("rd_c.c_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("rd_c.c_rd", c_rd, 32'hE3A0_1005);
    chk("rd_c.d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("rd_c.d_rd", d_rd, 32'd0);
    chk("rd_c.d_gnt", {31'b0, d_gnt}, 32'd0);

    // DMA write while idle, then read it back through the core
    d_req = 1; d_we = 1; d_adr = 32'h40; d_wd = 32'hDEAD_BEEF;
    #1;
    chk("wr_d.d_gnt", {31'b0, d_gnt}, 32'd1);
    chk("wr_d.c_gnt", {31'b0, c_gnt}, 32'd0);
    chk("wr_d.mem_en", {31'b0, mem_en}, 32'd1);
    chk("wr_d.mem_we", {31'b0, mem_we}, 32'd1);
    chk("wr_d.mem_adr", mem_adr, 32'h40);
    chk("wr_d.mem_wd", mem_wd, 32'hDEAD_BEEF);
    cyc();
    d_req = 0; d_we = 0;
    c_req = 1; c_adr = 32'h40;
    #1;
    chk("wr_d.no_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("wr_d.no_c_rvalid", {31'b0, c_rvalid}, 32'd0);
    chk("wr_d.rb_gnt", {31'b0, c_gnt}, 32'd1);
    cyc();
    c_req = 0;
    #1;
    chk("wr_d.rb_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("wr_d.rb_data", c_rd, 32'hDEAD_BEEF);

    // Contention aging: expected C,C,C,C,D,C,C,C,C,D
    c_req = 1; c_adr = 32'h0; d_req = 1; d_adr = 32'h8;
    prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_d = (i == 4) || (i == 9);
      #1;
      chk($sformatf("age[%0d].c_gnt", i), {31'b0, c_gnt}, {31'b0, !exp_d});
      chk($sformatf("age[%0d].d_gnt", i), {31'b0, d_gnt}, {31'b0, exp_d});
      if (i > 0) begin
        chk($sformatf("age[%0d].c_rvalid", i), {31'b0, c_rvalid}, {31'b0, !prev_d});
        chk($sformatf("age[%0d].d_rvalid", i), {31'b0, d_rvalid}, {31'b0, prev_d});
        chk($sformatf("age[%0d].c_rd", i), c_rd, prev_d ? 32'h0 : 32'hA000_0000);
        chk($sformatf("age[%0d].d_rd", i), d_rd, prev_d ? 32'hA000_0002 : 32'h0);
      end
      prev_d = exp_d;
      cyc();
    end
    c_req = 0; d_req = 0;
    #1;
    chk("age.last_d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("age.last_d_rd", d_rd, 32'hA000_0002);
    chk("age.last_c_rvalid", {31'b0, c_rvalid}, 32'd0);
    cyc();

    // Back-to-back core reads 0x0, 0x4
    c_req = 1; c_adr = 32'h0;
    #1 chk("b2b.gnt0", {31'b0, c_gnt}, 32'd1);
    cyc();
    c_adr = 32'h4;
    #1;
    chk("b2b.gnt1", {31'b0, c_gnt}, 32'd1);
    chk("b2b.rv0", {31'b0, c_rvalid}, 32'd1);
    chk("b2b.rd0", c_rd, 32'hA000_0000);
    cyc();
    c_req = 0;
    #1;
    chk("b2b.rv1", {31'b0, c_rvalid}, 32'd1);
    chk("b2b.rd1", c_rd, 32'hA000_0001);
    cyc();

    // Core read followed by a DMA read in the next cycle
    c_req = 1; c_adr = 32'h0;
    cyc();
    c_req = 0; d_req = 1; d_we = 0; d_adr = 32'hC;
    #1;
    chk("cd.c_rvalid", {31'b0, c_rvalid}, 32'd1);
    chk("cd.c_rd", c_rd, 32'hA000_0000);
    chk("cd.d_gnt", {31'b0, d_gnt}, 32'd1);
    cyc();
    d_req = 0;
    #1;
    chk("cd.d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk("cd.d_rd", d_rd, 32'hA000_0003);
    chk("cd.c_rvalid_off", {31'b0, c_rvalid}, 32'd0);
    chk("cd.c_rd_zero", c_rd, 32'd0);
    cyc();

    // DMA withdrawal clears aging: 3 denied, drop, reassert -> core wins 4 then D
    c_req = 1; c_adr = 32'h0; d_req = 1; d_adr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("wd.pre[%0d].c_gnt", i), {31'b0, c_gnt}, 32'd1);
      cyc();
    end
    d_req = 0;
    cyc();
    d_req = 1;
    for (int i = 0; i < 5; i++) begin
      exp_d = (i == 4);
      #1 chk($sformatf("wd.post[%0d].d_gnt", i), {31'b0, d_gnt}, {31'b0, exp_d});
      cyc();
    end
    c_req = 0; d_req = 0;
    cyc();

    // Reset in the data phase of a core read
    c_req = 1; c_adr = 32'h10;
    #1 chk("rst.gnt", {31'b0, c_gnt}, 32'd1);
    cyc();
    c_req = 0;
    reset = 1'b1;
    #1;
    chk("rst.c_rvalid", {31'b0, c_rvalid}, 32'd0);
    chk("rst.c_rd", c_rd, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    #1 chk_idle_outputs("post_rst");
    cyc();
    #1 chk_idle_outputs("post_rst2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle core between two requesters: the core (port C) and a DMA/debug master (port D).
- Each cycle, accepts at most one access from either port and drives the memory address phase. Routes read data back to the owner one cycle later.
- The core treats a missing grant as a stall and holds its FSM state (FETCH/MEMRD/MEMWR) until granted.
- Fixed priority favours the core. An aging counter guarantees DMA progress.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAXWAIT, 4, consecutive denied DMA cycles before DMA is promoted over the core (legal range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- c_req  in  1  core access request
- c_we  in  1  core write enable (valid with c_req)
- c_adr  in  AW  core byte address
- c_wd  in  DW  core write data
- c_gnt  out  1  core access accepted this cycle
- c_rd  out  DW  core read data
- c_rvalid  out  1  c_rd valid (one cycle after a core read grant)
- d_req, d_we, d_adr, d_wd  in  1/1/AW/DW  DMA request fields, same meaning as the core fields
- d_gnt, d_rd, d_rvalid  out  1/DW/1  DMA response fields, same meaning as the core fields
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_adr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  synchronous memory read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, wait_cnt=0. All outputs are 0: gnt, rvalid, mem_en, mem_we, mem_adr, mem_wd. c_rd and d_rd read 0 while rvalid=0.
- Request rules: a requester holds req/we/adr/wd stable from req rise until the cycle its gnt=1. Deasserting req before the grant is legal (the request is withdrawn, no access occurs).
- Arbitration: combinational in the same cycle. Priority:
  1. wait_cnt==MAXWAIT && d_req -> D
  2. c_req -> C
  3. d_req -> D
  4. otherwise, no grant
- Grant cycle: exactly one gnt is high. mem_en=1; mem_we/mem_adr/mem_wd come from the winner. With no winner, mem_en=0 and mem_we=0.
- Write latency: a write completes in its grant cycle; no rvalid follows.
- Read latency: 1 cycle. x_rvalid=1 and x_rd=mem_rd in cycle N+1 for a read granted in cycle N. The non-owner's rd is held at 0.
- Back-to-back: a new address phase may be granted in the same cycle as the previous read's data phase (full throughput, one access per cycle).
- Data-phase FSM:
  - states IDLE, RD_C, RD_D
  - next state = RD_C if c_gnt && !c_we; RD_D if d_gnt && !d_we; else IDLE
  - the transition is taken from every state
  - c_rvalid = (state==RD_C); d_rvalid = (state==RD_D)
- Aging counter wait_cnt (4 bits):
  - cleared when d_gnt or !d_req
  - increments when d_req && !d_gnt
  - saturates at MAXWAIT
- Simultaneous requests, both every cycle:
  - the core wins MAXWAIT cycles, then D wins one
  - the counter then clears and the pattern repeats
  - the core is never starved (D promotion lasts one grant)
- Reset mid-operation: a pending data phase is dropped and no rvalid is issued after reset. Requesters must re-request.

Decomposition:
- Shared package mem_pkg:
  - state encoding localparams IDLE=0, RD_C=1, RD_D=2
  - port index constants PORT_C=0, PORT_D=1
  - default AW/DW
- Sub-module arb_age_cnt: the saturating wait counter with promote output. It is small but reusable for future ports.
- Everything else is flat.

Test Plan:
- Core-only read: c_req=1, c_we=0, c_adr=0x10, mem holds 0xE3A01005 -> c_gnt=1 in cycle 0; c_rvalid=1, c_rd=0xE3A01005 in cycle 1; d_* outputs stay 0.
- DMA write while idle: d_req=1, d_we=1, d_adr=0x40, d_wd=0xDEADBEEF -> d_gnt=1, mem_en=1, mem_we=1, mem_adr=0x40 in the same cycle; no rvalid; a later core read of 0x40 returns 0xDEADBEEF.
- Contention aging, MAXWAIT=4: c_req and d_req held high for 10 cycles, all reads -> grant sequence C,C,C,C,D,C,C,C,C,D; each read's rvalid goes to the matching port one cycle later.
- Back-to-back reads: core reads 0x0 then 0x4 in consecutive cycles -> c_rvalid high in 2 consecutive cycles with the correct words. A DMA grant in the second cycle instead -> c_rvalid then d_rvalid.
- DMA withdrawal: d_req high for 3 denied cycles, then low -> wait_cnt returns to 0; after d_req is reasserted, the core wins the next 4 contention cycles.
- Reset mid-read: assert reset in the cycle after a core read grant -> c_rvalid=0 immediately and state=IDLE; after reset release, no spurious rvalid and all outputs are 0.
